// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types and defaults for the triggered waveform capture.
// Contents: capture FSM state encoding, RAM geometry defaults, digitron field offsets.
// No ports; imported by the capture top level.
package adc_capture_pkg;

    localparam int DEPTH_DEFAULT = 2000;
    localparam int AW_DEFAULT    = 11;
    localparam int DW_DEFAULT    = 8;

    // Field positions inside number_on_digitron.
    localparam int PEAK_LSB  = 0;
    localparam int TADDR_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: free-running clock divider producing a one-cycle sample strobe.
// Ports: clk, rst (sync, active-high) in; tick out, high when the count equals DIV-1.
// Count runs 0..DIV-1 and never stalls; no backpressure.
module sample_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/adc_capture.sv
// adc_capture: triggered ADC waveform capture into the shared waveform RAM write port.
// Ports: clk, rst, adc_data, trig_level, KEY_STATE in; address_b/data_b/wren_b (RAM write),
// capture_done, trig_addr, number_on_digitron out. Writes are registered, one cycle after the strobe.
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int DIV   = 10,
    parameter int PRE   = 500
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] adc_data,
    input  logic [DW-1:0] trig_level,
    input  logic [9:0]    KEY_STATE,
    output logic [AW-1:0] address_b,
    output logic [DW-1:0] data_b,
    output logic          wren_b,
    output logic          capture_done,
    output logic [AW-1:0] trig_addr,
    output logic [19:0]   number_on_digitron
);

    localparam logic [AW-1:0] WPTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
    // The triggering sample is written in WAIT_TRIG, so POST only adds DEPTH-PRE-1 more.
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE - 2);

    state_t        state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] cnt;
    logic [DW-1:0] peak;
    logic [DW-1:0] prev;
    logic          prev_valid;
    logic          key_q;
    logic          tick;
    logic          arm_edge;
    logic          level_hit;
    logic          trig_hit;
    logic          capturing;
    logic [19:0]   digitron_next;
    logic          unused_keys;

    sample_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign arm_edge    = KEY_STATE[0] & ~key_q;
    // Rising crossing needs a previous sample in this capture; a signal already
    // above the level at arm time never fires on its own.
    assign level_hit   = prev_valid && (prev < trig_level) && (adc_data >= trig_level);
    assign trig_hit    = level_hit || KEY_STATE[2];
    assign capturing   = (state == ST_PRE) || (state == ST_WAIT_TRIG) || (state == ST_POST);
    assign unused_keys = ^KEY_STATE[9:3];

    always_comb begin
        digitron_next = '0;
        digitron_next[PEAK_LSB +: DW]  = peak;
        digitron_next[TADDR_LSB +: AW] = trig_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            wptr               <= '0;
            cnt                <= '0;
            peak               <= '0;
            prev               <= '0;
            prev_valid         <= 1'b0;
            key_q              <= 1'b0;
            address_b          <= '0;
            data_b             <= '0;
            wren_b             <= 1'b0;
            capture_done       <= 1'b0;
            trig_addr          <= '0;
            number_on_digitron <= '0;
        end else begin
            key_q              <= KEY_STATE[0];
            wren_b             <= 1'b0;
            number_on_digitron <= digitron_next;

            if (KEY_STATE[1]) begin
                // Abort wins over everything else this cycle; results are kept.
                state <= ST_IDLE;
            end else if (arm_edge && (state == ST_IDLE || state == ST_DONE)) begin
                state        <= ST_PRE;
                wptr         <= '0;
                cnt          <= '0;
                peak         <= '0;
                prev_valid   <= 1'b0;
                capture_done <= 1'b0;
            end else if (tick && capturing) begin
                address_b  <= wptr;
                data_b     <= adc_data;
                wren_b     <= 1'b1;
                wptr       <= (wptr == WPTR_LAST) ? '0 : wptr + AW'(1);
                prev       <= adc_data;
                prev_valid <= 1'b1;
                if (adc_data > peak) begin
                    peak <= adc_data;
                end

                case (state)
                    ST_PRE: begin
                        if (cnt == PRE_LAST) begin
                            state <= ST_WAIT_TRIG;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (trig_hit) begin
                            trig_addr <= wptr;
                            state     <= ST_POST;
                            cnt       <= '0;
                        end
                    end
                    ST_POST: begin
                        if (cnt == POST_LAST) begin
                            state        <= ST_DONE;
                            capture_done <= 1'b1;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed bench for adc_capture with DEPTH=16, PRE=4, DIV=2.
// A table of capture scenarios is replayed in a loop; reset, wrap, abort and
// same-cycle events are covered by hand-written sequences afterwards.
module tb_adc_capture;

    localparam int DEPTH = 16;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DIV   = 2;
    localparam int PRE   = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] adc_data;
    logic [DW-1:0] trig_level;
    logic [9:0]    KEY_STATE;
    logic [AW-1:0] address_b;
    logic [DW-1:0] data_b;
    logic          wren_b;
    logic          capture_done;
    logic [AW-1:0] trig_addr;
    logic [19:0]   number_on_digitron;

    adc_capture #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .DIV   (DIV),
        .PRE   (PRE)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .adc_data           (adc_data),
        .trig_level         (trig_level),
        .KEY_STATE          (KEY_STATE),
        .address_b          (address_b),
        .data_b             (data_b),
        .wren_b             (wren_b),
        .capture_done       (capture_done),
        .trig_addr          (trig_addr),
        .number_on_digitron (number_on_digitron)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    level;
        int    start;
        int    step;
        int    force_at;      // raise force once this many writes were seen; 0 = never
        int    exp_trig;
        int    exp_writes;
        int    exp_peak;
        int    exp_last_addr;
    } scen_t;

    scen_t scen [4];

    int checks;
    int errors;
    int cyc;
    int wcount;
    int last_wr_cyc;
    bit wr_seen;
    int spacing_bad;
    int last_addr;
    int last_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and log any write pulse seen there.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (wren_b) begin
            if (wr_seen && (cyc - last_wr_cyc) != DIV) spacing_bad++;
            wr_seen     = 1'b1;
            last_wr_cyc = cyc;
            wcount++;
            last_addr = int'(address_b);
            last_data = int'(data_b);
        end
    endtask

    task automatic arm();
        KEY_STATE[0] = 1'b1;
        wcount       = 0;
        wr_seen      = 1'b0;
        spacing_bad  = 0;
        tick();
        KEY_STATE[0] = 1'b0;
    endtask

    task automatic wait_write(input string name);
        int start_cnt;
        start_cnt = wcount;
        for (int c = 0; c < 20 && wcount == start_cnt; c++) tick();
        check({name, "_timeout"}, wcount - start_cnt, 1);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_address_b"}, address_b, 0);
        check({pfx, "_data_b"}, data_b, 0);
        check({pfx, "_wren_b"}, wren_b, 0);
        check({pfx, "_capture_done"}, capture_done, 0);
        check({pfx, "_trig_addr"}, trig_addr, 0);
        check({pfx, "_digitron"}, number_on_digitron, 0);
    endtask

    task automatic run_capture(input scen_t s);
        bit done_seen;
        int n;
        int snap;
        trig_level = DW'(s.level);
        adc_data   = DW'(s.start);
        KEY_STATE  = '0;
        tick();
        arm();
        done_seen = 1'b0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            tick();
            if (wren_b) begin
                n = wcount - 1;
                check({s.name, "_addr"}, address_b, n % DEPTH);
                check({s.name, "_data"}, data_b, (s.start + s.step * n) & 255);
                adc_data = DW'(s.start + s.step * wcount);
                if (s.force_at > 0 && wcount >= s.force_at) KEY_STATE[2] = 1'b1;
            end
            if (capture_done) begin
                check({s.name, "_done_with_last_wr"}, wren_b, 1);
                done_seen = 1'b1;
            end
        end
        check({s.name, "_done"}, done_seen, 1);
        check({s.name, "_writes"}, wcount, s.exp_writes);
        check({s.name, "_trig_addr"}, trig_addr, s.exp_trig);
        check({s.name, "_spacing"}, spacing_bad, 0);
        check({s.name, "_last_addr"}, last_addr, s.exp_last_addr);
        tick();
        check({s.name, "_dig_peak"}, number_on_digitron[7:0], s.exp_peak);
        check({s.name, "_dig_taddr"}, number_on_digitron[18:8], s.exp_trig);
        check({s.name, "_dig_b19"}, number_on_digitron[19], 0);
        snap = wcount;
        repeat (10) tick();
        check({s.name, "_done_no_wr"}, wcount - snap, 0);
        check({s.name, "_done_hold"}, capture_done, 1);
        KEY_STATE[2] = 1'b0;
    endtask

    initial begin
        int k;
        int snap;
        checks = 0; errors = 0; cyc = 0; wcount = 0;
        last_wr_cyc = 0; wr_seen = 1'b0; spacing_bad = 0;
        last_addr = 0; last_data = 0;

        // Rising ramps: trigger lands on the first sample >= level after one below it.
        // Every scenario writes PRE + (trigger) + 11 samples plus any extra WAIT_TRIG ones.
        scen[0] = '{"level_ramp",      45,  0, 10, 0, 5, 17, 160,  0};
        scen[1] = '{"force_const",     45,  0,  0, 4, 4, 16,   0, 15};
        scen[2] = '{"level_equal",     90, 30, 15, 0, 4, 16, 255, 15};
        scen[3] = '{"level_and_force", 45,  0, 10, 5, 5, 17, 160,  0};

        rst        = 1'b1;
        adc_data   = '0;
        trig_level = 8'd45;
        KEY_STATE  = '0;

        // Reset and idle: ramping input never produces a write.
        repeat (3) begin
            tick();
            adc_data = adc_data + 8'd7;
        end
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (20) begin
            tick();
            adc_data = adc_data + 8'd7;
        end
        check("idle_no_wr", wcount, 0);
        check("idle_addr", address_b, 0);

        for (int i = 0; i < 4; i++) run_capture(scen[i]);

        // Input already above level: no trigger, pointer wraps; then 30 -> 60 fires.
        trig_level = 8'd45;
        adc_data   = 8'd100;
        KEY_STATE  = '0;
        arm();
        repeat (40) begin
            tick();
            if (wren_b) check("wrap_addr", address_b, (wcount - 1) % DEPTH);
        end
        check("wrap_no_done", capture_done, 0);
        check("wrap_count_ge17", wcount >= 17, 1);
        adc_data = 8'd30;
        wait_write("drop30");
        check("drop30_data", data_b, 30);
        adc_data = 8'd60;
        wait_write("rise60");
        check("rise60_data", data_b, 60);
        k = wcount - 1;
        tick();
        check("rise60_trig_addr", trig_addr, k % DEPTH);
        for (int c = 0; c < 100 && !capture_done; c++) tick();
        check("rise60_post_writes", wcount - 1 - k, DEPTH - PRE - 1);
        check("rise60_done", capture_done, 1);

        // Abort mid-POST, asserted so that it coincides with a strobe edge.
        adc_data  = 8'd0;
        KEY_STATE = '0;
        KEY_STATE[2] = 1'b1;
        arm();
        for (int c = 0; c < 50 && wcount < 8; c++) tick();
        check("abort_reach_post", wcount, 8);
        KEY_STATE[2] = 1'b0;
        tick();
        KEY_STATE[1] = 1'b1;
        tick();
        check("abort_wren", wren_b, 0);
        check("abort_done", capture_done, 0);
        check("abort_trig_kept", trig_addr, 4);
        KEY_STATE[1] = 1'b0;
        snap = wcount;
        repeat (10) tick();
        check("abort_idle_no_wr", wcount - snap, 0);
        arm();
        wait_write("rearm");
        check("rearm_addr", address_b, 0);
        KEY_STATE[1] = 1'b1;
        tick();
        KEY_STATE[1] = 1'b0;
        tick();

        // Arm and abort together from IDLE: nothing starts.
        snap = wcount;
        KEY_STATE[0] = 1'b1;
        KEY_STATE[1] = 1'b1;
        tick();
        KEY_STATE = '0;
        repeat (10) tick();
        check("arm_abort_no_wr", wcount - snap, 0);

        // Synchronous reset while waiting for a trigger.
        adc_data = 8'd100;
        arm();
        for (int c = 0; c < 50 && wcount < 6; c++) tick();
        check("rst_reach_wait", wcount, 6);
        rst = 1'b1;
        tick();
        check_outputs_zero("rst_mid");
        rst = 1'b0;
        snap = wcount;
        repeat (20) tick();
        check("rst_mid_no_wr", wcount - snap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
